// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, status codes and W-stage record
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RESP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd2;
    localparam logic [2:0] SINS = 3'd3;
    localparam logic [2:0] SHLT = 3'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } wbState_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        valid;
    } wReg_t;

    localparam wReg_t W_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        valE:  64'd0,
        valM:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE,
        valid: 1'b0
    };

    function automatic logic isFault(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - Saturating up-counter with enable and synchronous reset
module sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/writeback_pipe.sv
// rtl/writeback_pipe.sv - W pipeline register, register-file enables, RUN/HALT status, retire count
module writeback_pipe
    import y86_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       M_icode,
    input  logic [63:0]      M_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       M_dstE,
    input  logic [3:0]       M_dstM,
    input  logic             W_stall,
    input  logic             W_bubble,
    output logic [2:0]       W_stat,
    output logic [3:0]       W_icode,
    output logic [63:0]      W_valE,
    output logic [63:0]      W_valM,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic             w_weE,
    output logic             w_weM,
    output logic [2:0]       prog_stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    wReg_t    wReg;
    wReg_t    mReg;
    wbState_t state;
    wbState_t nextState;
    logic     running;
    logic     retireEn;
    logic     okValid;

    assign mReg = '{
        stat:  m_stat,
        icode: M_icode,
        valE:  M_valE,
        valM:  m_valM,
        dstE:  M_dstE,
        dstM:  M_dstM,
        valid: 1'b1
    };

    assign running = (state == RUN);
    assign okValid = running && wReg.valid && (wReg.stat == SAOK);

    // HALT freezes the register; stall beats bubble when both are raised
    always_ff @(posedge clk) begin
        if (reset) begin
            wReg <= W_BUBBLE;
        end else if (running && !W_stall) begin
            wReg <= W_bubble ? W_BUBBLE : mReg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (running && wReg.valid && isFault(wReg.stat)) begin
            nextState = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prog_stat <= SAOK;
        end else if (running && (nextState == HALT)) begin
            prog_stat <= wReg.stat;
        end
    end

    // A stalled instruction is counted once, on the edge it actually leaves W
    assign retireEn = okValid && !W_stall;

    sat_counter #(
        .WIDTH(CNT_W)
    ) retireCounter (
        .clk  (clk),
        .reset(reset),
        .en   (retireEn),
        .count(retired)
    );

    assign w_weE  = okValid && (wReg.dstE != RNONE);
    assign w_weM  = okValid && (wReg.dstM != RNONE);
    assign halted = (state == HALT);

    assign W_stat  = wReg.stat;
    assign W_icode = wReg.icode;
    assign W_valE  = wReg.valE;
    assign W_valM  = wReg.valM;
    assign W_dstE  = wReg.dstE;
    assign W_dstM  = wReg.dstM;

endmodule

// File: tb/tb_writeback_pipe.sv
// tb/tb_writeback_pipe.sv - Scoreboard bench for writeback_pipe with a transaction-level model
module tb_writeback_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  m_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;

    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        w_weE;
    logic        w_weM;
    logic [2:0]  prog_stat;
    logic        halted;
    logic [63:0] retired;

    logic [2:0]  s4Stat;
    logic [3:0]  s4Icode;
    logic [63:0] s4ValE;
    logic [63:0] s4ValM;
    logic [3:0]  s4DstE;
    logic [3:0]  s4DstM;
    logic        s4WeE;
    logic        s4WeM;
    logic [2:0]  s4ProgStat;
    logic        s4Halted;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    writeback_pipe #(.CNT_W(64)) dut (
        .clk(clk), .reset(reset), .m_stat(m_stat), .M_icode(M_icode),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .w_weE(w_weE), .w_weM(w_weM),
        .prog_stat(prog_stat), .halted(halted), .retired(retired)
    );

    writeback_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .m_stat(m_stat), .M_icode(M_icode),
        .M_valE(M_valE), .m_valM(m_valM), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble),
        .W_stat(s4Stat), .W_icode(s4Icode), .W_valE(s4ValE), .W_valM(s4ValM),
        .W_dstE(s4DstE), .W_dstM(s4DstM), .w_weE(s4WeE), .w_weM(s4WeM),
        .prog_stat(s4ProgStat), .halted(s4Halted), .retired(retired4)
    );

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        bit          valid;
    } instr_t;

    typedef struct {
        instr_t      w;
        logic        weE;
        logic        weM;
        logic [2:0]  ps;
        logic        halted;
        logic [63:0] ret;
        logic [3:0]  ret4;
    } expect_t;

    expect_t expQ[$];
    int compared = 0;
    int mismatched = 0;

    instr_t      mW;
    bit          mHalt;
    logic [2:0]  mPs;
    logic [63:0] mCnt;
    int          mCnt4;

    function automatic instr_t bubbleInstr();
        instr_t b;
        b.stat = 3'd1; b.icode = 4'd1; b.valE = 64'd0; b.valM = 64'd0;
        b.dstE = 4'd15; b.dstM = 4'd15; b.valid = 1'b0;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Instruction-level view: an instruction in W either retires, faults, or is held
    task automatic drive(input bit rst, input bit st, input bit bb, input logic [2:0] s,
                         input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        expect_t e;
        instr_t  in;
        bit      okInW;
        @(negedge clk);
        reset = rst; W_stall = st; W_bubble = bb;
        m_stat = s; M_icode = ic; M_valE = ve; m_valM = vm; M_dstE = de; M_dstM = dm;
        in.stat = s; in.icode = ic; in.valE = ve; in.valM = vm; in.dstE = de; in.dstM = dm;
        in.valid = 1'b1;
        if (rst) begin
            mW = bubbleInstr(); mHalt = 0; mPs = 3'd1; mCnt = 0; mCnt4 = 0;
        end else if (!mHalt) begin
            okInW = mW.valid && (mW.stat == 3'd1);
            if (okInW && !st) begin
                if (mCnt != 64'hFFFF_FFFF_FFFF_FFFF) mCnt = mCnt + 1;
                if (mCnt4 < 15) mCnt4 = mCnt4 + 1;
            end
            if (mW.valid && (mW.stat >= 3'd2) && (mW.stat <= 3'd4)) begin
                mHalt = 1; mPs = mW.stat;
            end
            if (!st) mW = bb ? bubbleInstr() : in;
        end
        e.w = mW;
        e.weE = !mHalt && mW.valid && (mW.stat == 3'd1) && (mW.dstE != 4'd15);
        e.weM = !mHalt && mW.valid && (mW.stat == 3'd1) && (mW.dstM != 4'd15);
        e.ps = mPs; e.halted = mHalt; e.ret = mCnt; e.ret4 = mCnt4[3:0];
        expQ.push_back(e);
    endtask

    task automatic load(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        drive(0, 0, 0, s, ic, ve, vm, de, dm);
    endtask

    task automatic randomCycle(input bit rst);
        logic [2:0] s;
        logic [3:0] de, dm;
        s  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
        de = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        dm = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
        drive(rst, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, s,
              4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("W_stat", 64'(W_stat), 64'(e.w.stat));
                check("W_icode", 64'(W_icode), 64'(e.w.icode));
                check("W_valE", W_valE, e.w.valE);
                check("W_valM", W_valM, e.w.valM);
                check("W_dstE", 64'(W_dstE), 64'(e.w.dstE));
                check("W_dstM", 64'(W_dstM), 64'(e.w.dstM));
                check("w_weE", 64'(w_weE), 64'(e.weE));
                check("w_weM", 64'(w_weM), 64'(e.weM));
                check("prog_stat", 64'(prog_stat), 64'(e.ps));
                check("halted", 64'(halted), 64'(e.halted));
                check("retired", retired, e.ret);
                check("retired4", 64'(retired4), 64'(e.ret4));
            end
        end
    end

    initial begin : stimulus
        int waitCycles;
        reset = 1; W_stall = 0; W_bubble = 0; m_stat = 3'd1; M_icode = 4'd1;
        M_valE = 0; m_valM = 0; M_dstE = 4'd15; M_dstM = 4'd15;
        mW = bubbleInstr(); mHalt = 0; mPs = 3'd1; mCnt = 0; mCnt4 = 0;

        drive(1, 0, 0, 3'd1, 4'd1, 0, 0, 4'd15, 4'd15);
        drive(1, 0, 0, 3'd1, 4'd1, 0, 0, 4'd15, 4'd15);
        load(3'd1, 4'd3, 64'h1234, 64'd0, 4'd0, 4'd15);
        load(3'd1, 4'd11, 64'h108, 64'hAA, 4'd4, 4'd3);
        drive(0, 0, 1, 3'd1, 4'd6, 64'h55, 64'h66, 4'd1, 4'd2);
        load(3'd1, 4'd2, 64'h77, 64'd0, 4'd5, 4'd15);
        for (int i = 0; i < 3; i++)
            drive(0, 1, 1, 3'd1, 4'd6, 64'(i + 100), 64'(i + 200), 4'd6, 4'd7);
        load(3'd1, 4'd6, 64'h999, 64'd0, 4'd8, 4'd15);
        load(3'd2, 4'd5, 64'h10, 64'hDEAD, 4'd15, 4'd2);
        load(3'd1, 4'd1, 64'd0, 64'd0, 4'd15, 4'd15);
        for (int i = 0; i < 10; i++) randomCycle(0);
        drive(1, 0, 0, 3'd1, 4'd1, 0, 0, 4'd15, 4'd15);
        load(3'd4, 4'd0, 64'd0, 64'd0, 4'd15, 4'd15);
        for (int i = 0; i < 4; i++) load(3'd1, 4'd3, 64'(i), 64'd0, 4'd1, 4'd15);
        drive(1, 0, 0, 3'd1, 4'd1, 0, 0, 4'd15, 4'd15);
        load(3'd1, 4'd3, 64'h42, 64'd0, 4'd9, 4'd15);
        load(3'd1, 4'd11, 64'h200, 64'h300, 4'd4, 4'd4);

        drive(1, 0, 0, 3'd1, 4'd1, 0, 0, 4'd15, 4'd15);
        for (int i = 0; i < 22; i++) load(3'd1, 4'd3, 64'(i), 64'd0, 4'(i % 15), 4'd15);
        load(3'd1, 4'd1, 64'd0, 64'd0, 4'd15, 4'd15);

        for (int i = 0; i < 3000; i++) begin
            randomCycle(mHalt ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0));
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

Write-back pipeline register and retirement controller for the Y86-64 pipeline. Latches the memory-stage result each cycle and drives the `W_*` bus consumed by decode for forwarding and register-file update. Generates the register-file write enables, tracks program status through a RUN/HALT state machine, and counts retired instructions. Sits between the memory stage and the decode/write-back stage.

## Interface
- `CNT_W`, 64: width of the retired-instruction counter.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `m_stat` in 3: memory-stage status (SAOK=1, SADR=2, SINS=3, SHLT=4).
- `M_icode` in 4: memory-stage icode.
- `M_valE` in 64: ALU result.
- `m_valM` in 64: memory read data.
- `M_dstE` in 4: E destination register (15 = RNONE).
- `M_dstM` in 4: M destination register.
- `W_stall` in 1: hold W contents.
- `W_bubble` in 1: load a bubble.
- `W_stat` out 3, `W_icode` out 4, `W_valE` out 64, `W_valM` out 64, `W_dstE` out 4, `W_dstM` out 4: registered W stage.
- `w_weE` out 1: write `W_valE` to `W_dstE` this cycle.
- `w_weM` out 1: write `W_valM` to `W_dstM` this cycle.
- `prog_stat` out 3: architectural program status.
- `halted` out 1: high in HALT state.
- `retired` out CNT_W: count of successfully retired instructions.

## Operation
- Bubble value: stat=SAOK, icode=INOP(1), valE=0, valM=0, dstE=dstM=RNONE, internal `W_valid`=0.
- Load priority per edge: `reset` > HALT freeze > `W_stall` > `W_bubble` > normal load (M inputs, `W_valid`=1).
- `W_stall` and `W_bubble` both high: stall wins, contents held.
- FSM states RUN, HALT. Reset → RUN.
- RUN → HALT on an edge where `W_valid`=1 and `W_stat`∈{SADR,SINS,SHLT}; `prog_stat` latches `W_stat` on that edge.
- HALT is absorbing until `reset`; all W registers, `prog_stat`, `retired` frozen; M inputs, stall, bubble ignored.
- `w_weE` = RUN & `W_valid` & `W_stat`==SAOK & `W_dstE`≠RNONE; `w_weM` likewise with `W_dstM`. Combinational from registered state; a faulting instruction (including HLT) never writes.
- Same-register hazard (`W_dstE`==`W_dstM`, e.g. popq %rsp): both enables asserted; the register file gives the M port priority.
- `retired` increments on edges in RUN where `W_valid` & `W_stat`==SAOK & !`W_stall`. Saturates at 2^CNT_W−1, no wrap. Bubbles are not counted; real `nop`s are.
- Values pass through unmodified; no arithmetic besides the counter.

## Timing
- Latency: M inputs at edge n appear on `W_*` after edge n (1 cycle).
- `w_weE`/`w_weM` are valid in the same cycle as the `W_*` values they qualify. The register file commits on the following edge.
- Fault visible on `W_stat` in cycle k → `halted`=1 and `prog_stat` updated from cycle k+1. Enables are low in cycle k.
- Reset values: `W_*` = bubble, `w_weE`=`w_weM`=0, `prog_stat`=SAOK, `halted`=0, `retired`=0.
- Reset mid-operation, including in HALT: next cycle is identical to the post-reset state. The in-flight W content is discarded without a write.

## Structure
- Shared package `y86_pkg`: icode constants (IHALT…IPOPQ), RNONE=15, RESP=4, stat codes SAOK/SADR/SINS/SHLT, bubble constants. Decode and the other stages import the same package.
- One natural sub-module: `sat_counter` (parameterized width, enable, synchronous reset, saturating).

## Test plan
- Reset, then load irmovq (`M_icode`=3, `M_dstE`=0, `M_valE`=0x1234, stat SAOK) → next cycle `W_valE`=0x1234, `W_dstE`=0, `w_weE`=1, `w_weM`=0; `retired`=1 one edge later.
- popq %rbx (dstE=4, valE=0x108, dstM=3, valM=0xAA) → both enables high; followed by `W_bubble` → `W_icode`=1, dsts=15, enables 0, `retired` unchanged.
- `W_stall`=1 and `W_bubble`=1 with new M data for 3 cycles → `W_*` held, `retired` unchanged; release → new data loads.
- mrmovq with `m_stat`=SADR, dstM=2 → W cycle shows `w_weM`=0; next cycle `halted`=1, `prog_stat`=2; later valid M inputs ignored for 10 cycles.
- halt instruction (`m_stat`=SHLT) → `prog_stat`=4, `halted`=1; assert `reset` → outputs return to reset values, RUN resumes on next load.
- CNT_W=4, retire 20 instructions → `retired` sticks at 15.
